// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM states and the M-group decode shared by alu_mdu
package alu_pkg;

  localparam int OP_W = 5;

  typedef enum logic [OP_W-1:0] {
    OP_AND    = 5'b00000, OP_OR     = 5'b00001, OP_ADD  = 5'b00010, OP_SUB  = 5'b00011,
    OP_XOR    = 5'b00100, OP_SRA    = 5'b00101,
    OP_EQ     = 5'b01000, OP_NE     = 5'b01001, OP_LT   = 5'b01010, OP_GE   = 5'b01011,
    OP_SLL    = 5'b01100, OP_SRL    = 5'b01101, OP_LTU  = 5'b01110, OP_GEU  = 5'b01111,
    OP_MUL    = 5'b10000, OP_MULH   = 5'b10001, OP_MULHSU = 5'b10010, OP_MULHU = 5'b10011,
    OP_DIV    = 5'b10100, OP_DIVU   = 5'b10101, OP_REM  = 5'b10110, OP_REMU = 5'b10111
  } alu_op_e;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mdu_state_e;

  function automatic logic is_mdu_op(input logic [OP_W-1:0] op);
    return op[4:3] == 2'b10;
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative unsigned shift-add multiplier / restoring divider
// hi_nx/lo_nx expose the post-step values so the caller can finalise on the last step.
module mdu_iter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  step,
  input  logic                  is_div,
  input  logic [DATA_WIDTH-1:0] a_mag,
  input  logic [DATA_WIDTH-1:0] b_mag,
  output logic [DATA_WIDTH-1:0] hi_nx,
  output logic [DATA_WIDTH-1:0] lo_nx,
  output logic                  done
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic                  div_q, div_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH:0]   sum, rsh, diff;

  always_comb begin
    sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : {DATA_WIDTH{1'b0}})};
    rsh  = {hi_q, lo_q[DATA_WIDTH-1]};
    diff = rsh - {1'b0, b_q};
    if (div_q) begin
      // Restoring step: keep the difference only when it did not borrow.
      if (!diff[DATA_WIDTH]) begin
        hi_nx = diff[DATA_WIDTH-1:0];
        lo_nx = {lo_q[DATA_WIDTH-2:0], 1'b1};
      end else begin
        hi_nx = rsh[DATA_WIDTH-1:0];
        lo_nx = {lo_q[DATA_WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_nx = sum[DATA_WIDTH:1];
      lo_nx = {sum[0], lo_q[DATA_WIDTH-1:1]};
    end
  end

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    b_d   = b_q;
    div_d = div_q;
    cnt_d = cnt_q;
    if (start) begin
      hi_d  = '0;
      lo_d  = a_mag;
      b_d   = b_mag;
      div_d = is_div;
      cnt_d = CNT_W'(DATA_WIDTH);
    end else if (step) begin
      hi_d  = hi_nx;
      lo_d  = lo_nx;
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - handshaked EX-stage ALU with iterative RV32M multiply/divide
module alu_mdu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 5,
  parameter int SHAMT_W       = $clog2(DATA_WIDTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     busy
);

  mdu_state_e            state_q, state_d;
  alu_op_e               op_q, op_d, op_in;
  logic                  neg_q, neg_d, neg_in;
  logic [DATA_WIDTH-1:0] result_q, result_d, alu_res, mdu_res;
  logic [DATA_WIDTH-1:0] a_mag, b_mag, hi_nx, lo_nx;
  logic [2*DATA_WIDTH-1:0] prod;
  logic [SHAMT_W-1:0]    shamt;
  logic                  a_sgn, b_sgn, accept, mdu_start, mdu_step, mdu_done;

  assign op_in     = alu_op_e'(Operation);
  assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY);
  assign ALUResult = result_q;

  always_comb begin
    shamt = SrcB[SHAMT_W-1:0];
    case (op_in)
      OP_AND:  alu_res = SrcA & SrcB;
      OP_OR:   alu_res = SrcA | SrcB;
      OP_ADD:  alu_res = SrcA + SrcB;
      OP_SUB:  alu_res = SrcA - SrcB;
      OP_XOR:  alu_res = SrcA ^ SrcB;
      OP_SRA:  alu_res = $signed(SrcA) >>> shamt;
      OP_EQ:   alu_res = DATA_WIDTH'(SrcA == SrcB);
      OP_NE:   alu_res = DATA_WIDTH'(SrcA != SrcB);
      OP_LT:   alu_res = DATA_WIDTH'($signed(SrcA) < $signed(SrcB));
      OP_GE:   alu_res = DATA_WIDTH'($signed(SrcA) >= $signed(SrcB));
      OP_SLL:  alu_res = SrcA << shamt;
      OP_SRL:  alu_res = SrcA >> shamt;
      OP_LTU:  alu_res = DATA_WIDTH'(SrcA < SrcB);
      OP_GEU:  alu_res = DATA_WIDTH'(SrcA >= SrcB);
      default: alu_res = '0;
    endcase
  end

  // Divide-by-zero keeps the raw all-ones quotient, so its negation is suppressed.
  always_comb begin
    a_sgn = (op_in == OP_MULH || op_in == OP_MULHSU || op_in == OP_DIV || op_in == OP_REM)
            && SrcA[DATA_WIDTH-1];
    b_sgn = (op_in == OP_MULH || op_in == OP_DIV || op_in == OP_REM) && SrcB[DATA_WIDTH-1];
    a_mag = a_sgn ? -SrcA : SrcA;
    b_mag = b_sgn ? -SrcB : SrcB;
    case (op_in)
      OP_DIV:             neg_in = (a_sgn ^ b_sgn) && (|SrcB);
      OP_REM:             neg_in = a_sgn;
      OP_MULH, OP_MULHSU: neg_in = a_sgn ^ b_sgn;
      default:            neg_in = 1'b0;
    endcase
  end

  mdu_iter #(.DATA_WIDTH(DATA_WIDTH)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .start  (mdu_start),
    .step   (mdu_step),
    .is_div (Operation[2]),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .hi_nx  (hi_nx),
    .lo_nx  (lo_nx),
    .done   (mdu_done)
  );

  always_comb begin
    prod = neg_q ? -{hi_nx, lo_nx} : {hi_nx, lo_nx};
    case (op_q)
      OP_MUL:                        mdu_res = prod[DATA_WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  mdu_res = prod[2*DATA_WIDTH-1:DATA_WIDTH];
      OP_DIV, OP_DIVU:               mdu_res = neg_q ? -lo_nx : lo_nx;
      default:                       mdu_res = neg_q ? -hi_nx : hi_nx;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    op_d      = op_q;
    neg_d     = neg_q;
    mdu_start = 1'b0;
    mdu_step  = 1'b0;
    case (state_q)
      BUSY: begin
        mdu_step = 1'b1;
        if (mdu_done) begin
          result_d = mdu_res;
          state_d  = DONE;
        end
      end
      default: begin
        if (state_q == DONE && out_ready) state_d = IDLE;
        if (accept) begin
          op_d  = op_in;
          neg_d = neg_in;
          if (is_mdu_op(Operation)) begin
            state_d   = BUSY;
            mdu_start = 1'b1;
          end else begin
            state_d  = DONE;
            result_d = alu_res;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      op_q     <= OP_AND;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// tb/tb_alu_mdu.sv - directed self-checking bench for alu_mdu
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  Operation;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_mdu dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Operation (Operation),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid  = v;
    Operation = op;
    SrcA      = a;
    SrcB      = b;
  endtask

  // Issues one op with out_ready=1; exp_lat counts edges after the accepting edge.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int n;
    int nb;
    int ir;
    @(negedge clk);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    drive(1'b1, op, a, b);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 32'd0);
    n = 0;
    nb = 0;
    ir = 0;
    while (!out_valid && n < 100) begin
      if (busy) nb++;
      if (in_ready) ir++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_result"}, ALUResult, exp);
    if (exp_lat > 0) begin
      chk({tag, "_busy_cycles"}, nb, exp_lat);
      chk({tag, "_in_ready_while_busy"}, ir, 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", ALUResult, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ADD then back-to-back SUB
    drive(1'b1, 5'b00010, 32'h7FFF_FFFF, 32'h1);
    @(negedge clk);
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_result", ALUResult, 32'h8000_0000);
    chk("add_in_ready", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 5'b00011, 32'd5, 32'd7);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 32'd0);
    chk("sub_valid", {31'd0, out_valid}, 32'd1);
    chk("sub_result", ALUResult, 32'hFFFF_FFFE);
    chk("sub_in_ready", {31'd0, in_ready}, 32'd1);

    run_op("sra",    5'b00101, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 0);
    run_op("lt",     5'b01010, 32'hFFFF_FFFF, 32'h1,         32'h1,         0);
    run_op("ltu",    5'b01110, 32'hFFFF_FFFF, 32'h1,         32'h0,         0);
    run_op("ge",     5'b01011, 32'hFFFF_FFFF, 32'h1,         32'h0,         0);
    run_op("geu",    5'b01111, 32'hFFFF_FFFF, 32'h1,         32'h1,         0);
    run_op("sll",    5'b01100, 32'h1,         32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("srl",    5'b01101, 32'h8000_0000, 32'h0000_0021, 32'h4000_0000, 0);
    run_op("xor",    5'b00100, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0, 0);
    run_op("eq",     5'b01000, 32'h1234_5678, 32'h1234_5678, 32'h1,         0);
    run_op("ne",     5'b01001, 32'h1234_5678, 32'h1234_5678, 32'h0,         0);
    run_op("undef",  5'b11111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         0);

    run_op("mulh_min",  5'b10001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32);
    run_op("mul",       5'b10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32);
    run_op("mulhu",     5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32);
    run_op("mulhsu",    5'b10010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32);
    run_op("mulh_neg",  5'b10001, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32);
    run_op("div_ovf",   5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32);
    run_op("rem_ovf",   5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32);
    run_op("divu_z",    5'b10101, 32'h7,         32'h0,         32'hFFFF_FFFF, 32);
    run_op("remu_z",    5'b10111, 32'h7,         32'h0,         32'h0000_0007, 32);
    run_op("div_negz",  5'b10100, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFFF, 32);
    run_op("rem_negz",  5'b10110, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 32);
    run_op("div_m7_2",  5'b10100, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 32);
    run_op("divu_big",  5'b10101, 32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, 32);

    // REM -7/2 with the consumer stalling for 5 cycles
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 5'b10110, 32'hFFFF_FFF9, 32'h2);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 32'd0);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("rem_m7_2_latency", n, 32);
    end
    for (int i = 0; i < 5; i++) begin
      chk("hold_result", ALUResult, 32'hFFFF_FFFF);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      drive(1'b1, 5'b00010, 32'd1, 32'd1);
      @(negedge clk);
    end
    chk("hold_result_end", ALUResult, 32'hFFFF_FFFF);
    drive(1'b0, 5'd0, 32'd0, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("hold_release_valid", {31'd0, out_valid}, 32'd0);
    chk("hold_release_result", ALUResult, 32'hFFFF_FFFF);

    // Reset in the middle of a DIVU
    drive(1'b1, 5'b10101, 32'd100, 32'd3);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 32'd0);
    repeat (9) @(negedge clk);
    chk("divu_mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_result", ALUResult, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    run_op("and_after_rst", 5'b00000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
Parametrised, handshaked successor to the single-cycle ALU. It adds signed/unsigned compares, arithmetic shift right, and the RV32M multiply/divide/remainder group.
- Logic, compare and shift ops complete with one registered cycle of latency.
- M-extension ops run in an iterative engine with fixed multi-cycle latency.
- Sits in the EX stage; the hazard unit stalls the pipeline on in_ready/out_valid.

Parameters:
DATA_WIDTH, 32, operand/result width (even, >=8)
OPCODE_LENGTH, 5, Operation field width
SHAMT_W, $clog2(DATA_WIDTH), shift-amount bits taken from SrcB LSBs

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  Operation/SrcA/SrcB valid this cycle
in_ready  output  1  unit can accept an operation this cycle
Operation  input  OPCODE_LENGTH  operation code
SrcA  input  DATA_WIDTH  operand A
SrcB  input  DATA_WIDTH  operand B
out_valid  output  1  ALUResult valid
out_ready  input  1  consumer accepts result
ALUResult  output  DATA_WIDTH  registered result
busy  output  1  iterative engine running

Behaviour:
- Opcodes:
  - 00000 AND, 00001 OR, 00010 ADD, 00011 SUB, 00100 XOR, 00101 SRA.
  - 01000 EQ, 01001 NE, 01010 LT (signed), 01011 GE (signed), 01100 SLL, 01101 SRL, 01110 LTU, 01111 GEU.
  - 10000 MUL, 10001 MULH, 10010 MULHSU, 10011 MULHU, 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU.
  - Any other code: result 0, single-cycle path.
- Compare ops return 1 or 0, zero-extended to DATA_WIDTH.
- Shifts use SrcB[SHAMT_W-1:0] only; upper bits of SrcB are ignored.
- ADD/SUB/MUL wrap modulo 2^DATA_WIDTH. MULH* return the upper DATA_WIDTH bits of the 2*DATA_WIDTH product.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_valid && in_ready latches operands and opcode.
    - Single-cycle op: go to DONE with the result registered; out_valid=1 next cycle (latency 1).
    - M op: go to BUSY and load a counter with DATA_WIDTH.
  - BUSY: one shift-add (mul) or restoring-subtract (div) step per cycle; counter decrements. At counter==1, finalise sign correction and go to DONE.
    - out_valid asserts exactly DATA_WIDTH+1 cycles after acceptance, for every M op including the special cases below.
  - DONE: out_valid=1; ALUResult held stable while !out_ready.
    - out_ready && !in_valid: go to IDLE.
    - out_ready && in_valid: accept the new op in the same cycle (back-to-back) and go to DONE or BUSY.
- in_ready = (state==IDLE) || (state==DONE && out_ready). in_ready is 0 in BUSY; inputs are ignored while in_ready=0.
- busy = (state==BUSY).
- Divide special cases (fixed latency preserved):
  - Divide by zero: DIV/DIVU quotient = all-ones; REM/REMU = SrcA.
  - Signed overflow (SrcA = most-negative, SrcB = -1): DIV = most-negative; REM = 0.
- Signed ops: operands are converted to magnitudes at acceptance. Quotient sign = signA^signB; remainder sign = signA. MULHSU treats SrcA signed, SrcB unsigned.
- Reset (any cycle, including mid-BUSY):
  - State goes to IDLE; the in-flight op is discarded.
  - out_valid=0, ALUResult=0, busy=0, counter=0.
  - in_ready=1 from the first cycle after reset deasserts.
- reset has priority over any handshake in the same cycle.

Decomposition:
- Shared package alu_pkg:
  - alu_op_e enum (OPCODE_LENGTH-bit codes above).
  - mdu_state_e {IDLE,BUSY,DONE}.
  - is_mdu_op() function.
- Sub-module mdu_iter: iterative unsigned multiplier/divider with start/step/done, magnitude operands and DATA_WIDTH counter.
- The alu_mdu top owns the FSM, handshake, single-cycle datapath, sign handling and special cases.

Test Plan:
- ADD 0x7FFFFFFF+1, then back-to-back SUB 5-7 with out_ready=1 -> 0x80000000 at cycle 1, 0xFFFFFFFE at cycle 2; in_ready stays 1.
- SRA 0x80000000 by SrcB=0x24 (shamt 4) -> 0xF8000000. LT 0xFFFFFFFF,1 -> 1. LTU same operands -> 0.
- MULH 0x80000000*0x80000000 -> 0x40000000 at exactly 33 cycles after acceptance; busy=1 for 32 cycles; in_ready=0 throughout.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0; DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7; all at 33-cycle latency.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF. Hold out_ready=0 for 5 cycles -> result stable, in_ready=0, no new op accepted.
- Assert reset at BUSY cycle 10 of a DIVU -> next cycle out_valid=0, ALUResult=0, busy=0, in_ready=1. A subsequent AND 0xF0F0&0xFF00 -> 0xF000.
